hw_stack: RTL and testbench

- LIFO stack unit that serves the controller's push/pop commands for call/return addresses and data push/pop.
- Sits beside the datapath: the controller issues push/pop, the datapath supplies din and consumes dout as top-of-stack.
- Single clock, registered storage.
- Reports full/empty/occupancy and sticky overflow/underflow errors for halt/debug logic.

---
 rtl/hw_stack_pkg.sv | 54 +++++
 rtl/stack_regfile.sv | 33 +++
 rtl/hw_stack.sv | 107 ++++++++++
 tb/tb_hw_stack.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/hw_stack_pkg.sv
// rtl/hw_stack_pkg.sv - shared constants, operation decode types and decode helper for hw_stack
//
// Purpose: default stack geometry shared by the controller, datapath and
// hw_stack, plus the per-cycle command decode used by the stack control.
// Ports: none (package).
package hw_stack_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [2:0] {
    OP_HOLD    = 3'd0,
    OP_CLR     = 3'd1,
    OP_PUSH    = 3'd2,
    OP_POP     = 3'd3,
    OP_REPLACE = 3'd4
  } op_t;

  typedef struct packed {
    op_t  op;
    logic set_overflow;
    logic set_underflow;
  } ctl_t;

  // Resolves one cycle's push/pop/clr request against the current fill state.
  // Illegal halves of a request are dropped and only raise the sticky flag.
  function automatic ctl_t stack_decode(input logic clr, input logic push,
                                        input logic pop, input logic empty,
                                        input logic full);
    ctl_t c;
    c.op            = OP_HOLD;
    c.set_overflow  = 1'b0;
    c.set_underflow = 1'b0;
    if (clr) begin
      c.op = OP_CLR;
    end else if (push && pop) begin
      if (empty) begin
        // Pop half has nothing to remove; the push half still lands.
        c.op            = OP_PUSH;
        c.set_underflow = 1'b1;
      end else begin
        c.op = OP_REPLACE;
      end
    end else if (push) begin
      if (full) c.set_overflow = 1'b1;
      else      c.op = OP_PUSH;
    end else if (pop) begin
      if (empty) c.set_underflow = 1'b1;
      else       c.op = OP_POP;
    end
    return c;
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// rtl/stack_regfile.sv - DEPTH x WIDTH register array, one write port, one async read port
//
// Purpose: entry storage for hw_stack. No reset; contents are only
// meaningful below the owner's occupancy count.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write index
//   wdata - write data
//   raddr - read index
//   rdata - combinational read data
module stack_regfile #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hw_stack.sv
// rtl/hw_stack.sv - LIFO stack with occupancy, full/empty and sticky overflow/underflow
//
// Purpose: serves controller push/pop commands; the datapath supplies din
// and consumes dout as top-of-stack. Holds the count register, error flags
// and control decode; entries live in stack_regfile.
// Ports:
//   clk       - clock, all state updates on rising edge
//   rst       - asynchronous active-low reset
//   push      - write din onto the stack
//   pop       - remove the top entry
//   clr       - synchronous clear of entries and error flags, overrides push/pop
//   din       - data to push
//   dout      - top of stack, 0 when empty
//   full      - count == DEPTH
//   empty     - count == 0
//   count     - occupancy 0..DEPTH
//   overflow  - sticky, push attempted while full
//   underflow - sticky, pop attempted while empty
module hw_stack
  import hw_stack_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  ctl_t             ctl;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign ctl   = stack_decode(clr, push, pop, empty, full);

  // Write index: next free slot on push, current top on replace.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    case (ctl.op)
      OP_PUSH: begin
        we    = 1'b1;
        waddr = AW'(count);
      end
      OP_REPLACE: begin
        we    = 1'b1;
        waddr = AW'(count - CW'(1));
      end
      default: ;
    endcase
  end

  // Read index forced to 0 when empty so it never leaves the array range;
  // the value is masked below anyway.
  assign raddr = empty ? '0 : AW'(count - CW'(1));
  assign dout  = empty ? '0 : rdata;

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (ctl.op)
        OP_CLR:  count <= '0;
        OP_PUSH: count <= count + CW'(1);
        OP_POP:  count <= count - CW'(1);
        default: ;
      endcase
      if (ctl.op == OP_CLR) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        overflow  <= overflow  | ctl.set_overflow;
        underflow <= underflow | ctl.set_underflow;
      end
    end
  end

endmodule

// File: tb/tb_hw_stack.sv
// tb/tb_hw_stack.sv - self-checking bench for hw_stack with queue reference model
module tb_hw_stack;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          clr = 1'b0;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  dout;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  hw_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clr       (clr),
    .din       (din),
    .dout      (dout),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  logic [W-1:0] mq[$];
  bit           m_ovf = 1'b0;
  bit           m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // LIFO semantics in plain queue terms: back of the queue is the top.
  task automatic model_apply(input logic p, input logic q, input logic c, input logic [W-1:0] d);
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (p && q) begin
      if (mq.size() == 0) begin
        mq.push_back(d);
        m_unf = 1'b1;
      end else begin
        void'(mq.pop_back());
        mq.push_back(d);
      end
    end else if (p) begin
      if (mq.size() == D) m_ovf = 1'b1;
      else mq.push_back(d);
    end else if (q) begin
      if (mq.size() == 0) m_unf = 1'b1;
      else void'(mq.pop_back());
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] exp_dout;
    exp_dout = (mq.size() != 0) ? mq[mq.size()-1] : '0;
    chk({tag, ".count"},     32'(count),     32'(mq.size()));
    chk({tag, ".dout"},      32'(dout),      32'(exp_dout));
    chk({tag, ".full"},      32'(full),      32'(mq.size() == D));
    chk({tag, ".empty"},     32'(empty),     32'(mq.size() == 0));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  task automatic step(input string tag, input logic p, input logic q, input logic c,
                      input logic [W-1:0] d);
    @(negedge clk);
    push = p;
    pop  = q;
    clr  = c;
    din  = d;
    @(posedge clk);
    model_apply(p, q, c, d);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] xval;
    xval = 'x;

    // Reset then idle
    #2;
    model_clear();
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
    step("idle", 1'b0, 1'b0, 1'b0, xval);

    // Fill to full, then overflow
    step("push11", 1'b1, 1'b0, 1'b0, 8'h11);
    step("push22", 1'b1, 1'b0, 1'b0, 8'h22);
    step("push33", 1'b1, 1'b0, 1'b0, 8'h33);
    step("push44", 1'b1, 1'b0, 1'b0, 8'h44);
    chk("full_after_4", 32'(full), 32'd1);
    step("push55_full", 1'b1, 1'b0, 1'b0, 8'h55);
    chk("ovf_dout_const", 32'(dout), 32'h44);
    chk("ovf_count_const", 32'(count), 32'd4);

    // Drain, then underflow
    step("pop1", 1'b0, 1'b1, 1'b0, xval);
    chk("pop1_const", 32'(dout), 32'h33);
    step("pop2", 1'b0, 1'b1, 1'b0, xval);
    step("pop3", 1'b0, 1'b1, 1'b0, xval);
    chk("pop3_const", 32'(dout), 32'h11);
    step("pop4", 1'b0, 1'b1, 1'b0, xval);
    step("pop5_empty", 1'b0, 1'b1, 1'b0, xval);
    chk("unf_const", 32'(underflow), 32'd1);

    // Replace on top, then push+pop on empty
    step("clr0", 1'b0, 1'b0, 1'b1, xval);
    step("pushA", 1'b1, 1'b0, 1'b0, 8'h11);
    step("pushB", 1'b1, 1'b0, 1'b0, 8'h22);
    step("replace99", 1'b1, 1'b1, 1'b0, 8'h99);
    chk("replace_const", 32'(dout), 32'h99);
    step("pop_after_replace", 1'b0, 1'b1, 1'b0, xval);
    chk("pop_after_replace_const", 32'(dout), 32'h11);
    step("pop_to_empty", 1'b0, 1'b1, 1'b0, xval);
    step("pushpop_empty77", 1'b1, 1'b1, 1'b0, 8'h77);
    chk("pushpop_empty_unf", 32'(underflow), 32'd1);

    // Replace while full is legal
    step("fill2", 1'b1, 1'b0, 1'b0, 8'h01);
    step("fill3", 1'b1, 1'b0, 1'b0, 8'h02);
    step("fill4", 1'b1, 1'b0, 1'b0, 8'h03);
    step("replace_full", 1'b1, 1'b1, 1'b0, 8'h5A);
    step("push_full_ovf", 1'b1, 1'b0, 1'b0, 8'hEE);

    // clr beats push, nothing written
    step("clr_with_push", 1'b1, 1'b0, 1'b1, 8'hAA);
    chk("clr_count_const", 32'(count), 32'd0);
    step("push_after_clr", 1'b1, 1'b0, 1'b0, 8'hAA);
    chk("push_after_clr_const", 32'(dout), 32'hAA);

    // Async reset between edges with entries present
    step("pre_rst2", 1'b1, 1'b0, 1'b0, 8'hB2);
    step("pre_rst3", 1'b1, 1'b0, 1'b0, 8'hB3);
    @(negedge clk);
    push = 1'b0;
    din  = xval;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    model_clear();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    step("pop_after_rst", 1'b0, 1'b1, 1'b0, xval);

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      logic p, q, c;
      logic [W-1:0] d;
      c = ($urandom_range(0, 99) < 3);
      p = ($urandom_range(0, 1) == 1);
      q = ($urandom_range(0, 1) == 1);
      d = p ? W'($urandom) : xval;
      step($sformatf("rnd%0d", i), p, q, c, d);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
